// File: rtl/result_seg7_pkg.sv
// Shared types and constants for the result-to-seven-segment display path.
// Segment codes are active-low, bit order gfedcba.
package result_seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_LOAD    = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Ports:
//   digit : 4-bit BCD value
//   seg_c : gfedcba segments, active-low; non-decimal codes render blank
module bcd_to_seg7
    import result_seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (digit)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_seg7_display.sv
// Accepts a binary result word over valid/ready, converts it to BCD with an
// iterative shift-add-3 (one bit per cycle) and shows it on active-low
// seven-segment digits.
// Ports:
//   iCLOCK       : clock
//   inRESET_SYNC : synchronous reset, active-low
//   iVALID/iDATA : result word handshake (producer holds until accepted)
//   oREADY       : high while idle and able to accept a word
//   oDONE        : one-cycle pulse when oHEX updates
//   oHEX         : P_DIGITS x 7 segments, digit 0 (units) in [6:0]
module result_seg7_display
    import result_seg7_pkg::*;
#(
    parameter int unsigned P_WIDTH         = 5,
    parameter int unsigned P_DIGITS        = 2,
    parameter int unsigned P_BLANK_LEADING = 1
) (
    input  logic                  iCLOCK,
    input  logic                  inRESET_SYNC,
    input  logic                  iVALID,
    input  logic [P_WIDTH-1:0]    iDATA,
    output logic                  oREADY,
    output logic                  oDONE,
    output logic [P_DIGITS*7-1:0] oHEX
);

    localparam int unsigned BCD_W = 4 * P_DIGITS;
    localparam int unsigned SR_W  = BCD_W + P_WIDTH;
    localparam int unsigned CNT_W = $clog2(P_WIDTH) + 1;
    localparam int unsigned HEX_W = 7 * P_DIGITS;

    state_e             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d, sr_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [HEX_W-1:0]   hex_q, hex_d;
    logic [HEX_W-1:0]   seg_c;
    logic               lead_zero;

    // One decoder per BCD nibble of the shift register
    for (genvar k = 0; k < P_DIGITS; k++) begin : g_dig
        bcd_to_seg7 u_dec (
            .digit (sr_q[P_WIDTH + 4*k +: 4]),
            .seg_c (seg_c[7*k +: 7])
        );
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        hex_d     = hex_q;
        sr_adj    = sr_q;
        lead_zero = 1'b1;

        // Add-3 correction on every BCD nibble that would overflow when doubled
        for (int k = 0; k < int'(P_DIGITS); k++) begin
            if (sr_adj[P_WIDTH + 4*k +: 4] >= 4'd5) begin
                sr_adj[P_WIDTH + 4*k +: 4] = sr_adj[P_WIDTH + 4*k +: 4] + 4'd3;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (iVALID) begin
                    sr_d    = {BCD_W'(0), iDATA};
                    cnt_d   = '0;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                sr_d  = SR_W'({sr_adj, 1'b0});
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(P_WIDTH - 1)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Walk from the most significant digit down, blanking zeros
                // until the first non-zero digit; the units digit always shows.
                for (int k = int'(P_DIGITS) - 1; k >= 0; k--) begin
                    if ((P_BLANK_LEADING != 0) && (k > 0) && lead_zero &&
                        (sr_q[P_WIDTH + 4*k +: 4] == 4'd0)) begin
                        hex_d[7*k +: 7] = SEG_BLANK;
                    end else begin
                        hex_d[7*k +: 7] = seg_c[7*k +: 7];
                        lead_zero       = 1'b0;
                    end
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge iCLOCK) begin
        if (!inRESET_SYNC) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            hex_q   <= {P_DIGITS{SEG_BLANK}};
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            hex_q   <= hex_d;
        end
    end

    assign oREADY = ready_q;
    assign oDONE  = done_q;
    assign oHEX   = hex_q;

endmodule

// File: tb/tb_result_seg7_display.sv
// Self-checking bench for result_seg7_display: directed and randomized words
// compared against a decimal reference model of the display.
module tb_result_seg7_display;

    localparam int W = 5;
    localparam int D = 2;
    localparam int HW = 7 * D;
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [HW-1:0] ALL_BLANK = 14'h3FFF;

    logic          clk;
    logic          rst_n;
    logic          vld;
    logic [W-1:0]  data;
    logic          rdy;
    logic          done;
    logic [HW-1:0] hex;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_hs     = 0;
    int n_done   = 0;
    int acc_cyc[$];
    logic [HW-1:0] shown;

    result_seg7_display #(
        .P_WIDTH         (W),
        .P_DIGITS        (D),
        .P_BLANK_LEADING (1)
    ) dut (
        .iCLOCK       (clk),
        .inRESET_SYNC (rst_n),
        .iVALID       (vld),
        .iDATA        (data),
        .oREADY       (rdy),
        .oDONE        (done),
        .oHEX         (hex)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Observe handshakes and done pulses shortly after the falling edge
    always @(negedge clk) begin
        #1;
        if (rst_n && vld && rdy) begin
            n_hs++;
            acc_cyc.push_back(cyc);
        end
        if (done) n_done++;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Reference display: decimal digits, blanks above the most significant digit
    function automatic logic [HW-1:0] model_hex(input int v);
        logic [HW-1:0] h;
        int n;
        int r;
        n = 1;
        r = v / 10;
        while (r > 0) begin
            n++;
            r = r / 10;
        end
        r = v;
        h = '0;
        for (int k = 0; k < D; k++) begin
            if (k >= n) h[7*k +: 7] = 7'h7F;
            else        h[7*k +: 7] = SEG_TAB[r % 10];
            r = r / 10;
        end
        return h;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One word through a full handshake, checking busy window, update and hold
    task automatic xfer(input int v, input bit noisy);
        int hs0;
        int dn0;
        chk("rdy_idle", 32'(rdy), 32'd1);
        hs0  = n_hs;
        dn0  = n_done;
        vld  = 1'b1;
        data = W'(v);
        @(negedge clk);
        for (int k = 0; k <= W; k++) begin
            chk("busy", 32'({rdy, done, hex}), 32'({2'b00, shown}));
            if (noisy) begin
                vld  = 1'($urandom_range(0, 1));
                data = W'(25);
            end else begin
                vld  = 1'b0;
                data = W'($urandom);
            end
            @(negedge clk);
        end
        vld   = 1'b0;
        shown = model_hex(v);
        chk("update", 32'({rdy, done, hex}), 32'({2'b11, shown}));
        @(negedge clk);
        chk("hold", 32'({rdy, done, hex}), 32'({2'b10, shown}));
        chk("hs_count", 32'(n_hs - hs0), 32'd1);
        chk("done_count", 32'(n_done - dn0), 32'd1);
    endtask

    initial begin
        int words[3];
        int order[32];
        int hs0;
        int dn0;
        int t;
        int j;
        int tmp;

        rst_n = 1'b0;
        vld   = 1'b0;
        data  = '0;
        shown = ALL_BLANK;
        repeat (3) @(negedge clk);
        chk("reset", 32'({rdy, done, hex}), 32'({2'b10, ALL_BLANK}));
        rst_n = 1'b1;

        // Idle after reset: display blank, ready, no done
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle", 32'({rdy, done, hex}), 32'({2'b10, ALL_BLANK}));
        end

        // Single word with full timing check
        xfer(19, 1'b0);

        // Back-to-back words with iVALID held high
        words = '{31, 0, 7};
        acc_cyc.delete();
        vld  = 1'b1;
        data = W'(words[0]);
        for (int i = 0; i < 3; i++) begin
            t = 0;
            @(negedge clk);
            while (!done && t < 30) begin
                @(negedge clk);
                t++;
            end
            shown = model_hex(words[i]);
            chk("b2b_update", 32'({rdy, done, hex}), 32'({2'b11, shown}));
            if (i < 2) data = W'(words[i + 1]);
            else       vld  = 1'b0;
        end
        @(negedge clk);
        chk("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
        if (acc_cyc.size() == 3) begin
            chk("b2b_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
            chk("b2b_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'(W + 2));
        end

        // Input noise during conversion is ignored; 25 then taken from idle
        xfer(10, 1'b1);
        xfer(25, 1'b0);

        // Reset three edges into a conversion, with iVALID held during reset
        hs0  = n_hs;
        dn0  = n_done;
        vld  = 1'b1;
        data = W'(28);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        shown = ALL_BLANK;
        chk("mid_reset", 32'({rdy, done, hex}), 32'({2'b10, shown}));
        @(negedge clk);
        chk("reset_valid", 32'({rdy, done, hex}), 32'({2'b10, shown}));
        rst_n = 1'b1;
        vld   = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            chk("post_reset", 32'({rdy, done, hex}), 32'({2'b10, shown}));
        end
        chk("reset_no_done", 32'(n_done - dn0), 32'd0);
        chk("reset_hs", 32'(n_hs - hs0), 32'd1);
        xfer(28, 1'b0);

        // Full range in shuffled order with random idle gaps
        for (int i = 0; i < 32; i++) order[i] = i;
        for (int i = 31; i > 0; i--) begin
            j        = int'($urandom_range(0, i));
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        hs0 = n_hs;
        dn0 = n_done;
        for (int i = 0; i < 32; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            xfer(order[i], 1'($urandom_range(0, 1)));
        end
        chk("sweep_hs", 32'(n_hs - hs0), 32'd32);
        chk("sweep_done_eq_hs", 32'(n_done - dn0), 32'(n_hs - hs0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/result_seg7_display.md
Name: result_seg7_display

Overview:
- Consumer end of the adder result path: accepts a binary result word over a valid/ready handshake and shows it in decimal on active-low seven-segment digits.
- Conversion is an iterative shift-add-3 (double dabble), one input bit per cycle.
- Sits between the adder output and the board HEX pins, replacing raw LED display of the result.

Parameters:
- P_WIDTH, 5, width of the binary result input. Default covers a 4-bit sum plus carry, range 0..31.
- P_DIGITS, 2, number of decimal digits driven. Legal only when 10^P_DIGITS > 2^P_WIDTH-1.
- P_BLANK_LEADING, 1, when 1, leading zero digits are blanked (digit 0 is never blanked).

Ports:
- iCLOCK  input  1  single clock.
- inRESET_SYNC  input  1  synchronous reset, active-low.
- iVALID  input  1  result word present on iDATA.
- iDATA  input  P_WIDTH  unsigned binary result.
- oREADY  output  1  block can accept a word.
- oDONE  output  1  one-cycle pulse when the displayed value updates.
- oHEX  output  P_DIGITS*7  segments gfedcba, active-low; digit 0 (units) in bits [6:0].

Behaviour:
- Clock and reset: one clock, iCLOCK. Reset is synchronous and active-low on inRESET_SYNC, sampled at the iCLOCK edge.
- Reset values:
  - state IDLE, so oREADY=1.
  - oDONE=0.
  - every oHEX digit = 7'h7F (blank).
  - shift register and counter cleared.
- States: IDLE, CONVERT, LOAD.
- IDLE:
  - oREADY=1.
  - Accept at the edge where iVALID && oREADY. At that edge: load iDATA into the binary part of the shift register, clear the BCD part, set cnt=0, go to CONVERT.
- CONVERT:
  - oREADY=0.
  - Each edge: add 3 to every BCD nibble >= 5, then shift the whole register left 1, then cnt++.
  - After P_WIDTH shifts (edge P_WIDTH counted from the accept edge = edge 0), go to LOAD.
- LOAD:
  - oREADY=0.
  - At the next edge (edge P_WIDTH+1): register the decoded digits into oHEX, pulse oDONE=1 for exactly that cycle, go to IDLE.
- Latency: oHEX changes at edge P_WIDTH+1 after the accept edge (6 cycles at default).
- Throughput: the earliest next accept is edge P_WIDTH+2, i.e. one word per P_WIDTH+2 cycles.
- iVALID while oREADY=0 is ignored and not queued; the producer must hold iVALID/iDATA until the handshake.
- oHEX holds its last value indefinitely between updates.
- Blanking: with P_BLANK_LEADING=1, digit k>0 is 7'h7F when it and all higher digits are 0. A value of 0 shows "0" on digit 0 only.
- Segment codes (0..9): 40,79,24,30,19,12,02,78,00,10 (hex, 7-bit).
- BCD nibble values > 9 cannot occur for legal parameters; the decoder maps them to 7'h7F defensively.
- Reset mid-conversion:
  - abandons the word, returns to IDLE, blanks oHEX, oDONE=0.
  - no partial update is ever visible on oHEX.
- Reset asserted together with iVALID: reset wins and the word is not accepted.

Decomposition:
- Package result_seg7_pkg holds:
  - state enum typedef (IDLE/CONVERT/LOAD).
  - segment code constants SEG_0..SEG_9 and SEG_BLANK=7'h7F.
- Sub-module bcd_to_seg7: combinational 4-bit digit to 7-bit active-low segment decoder, instantiated once per digit (generate loop).
- The FSM, shift register and counter stay in result_seg7_display.

Test Plan:
- Reset, then idle 10 cycles → oHEX=14'h3FFF, oREADY=1, oDONE=0 throughout.
- Send iDATA=19 → at edge 6 after accept: oHEX[13:7]=7'h79, oHEX[6:0]=7'h10, oDONE high exactly 1 cycle, oREADY low for edges 1..6.
- Send 31, then 0, then 7 back-to-back with iVALID held continuously → accepts spaced exactly 7 cycles apart. Displays, in order:
  - 31: {30,79}.
  - 0: {7F,40}.
  - 7: {7F,78}.
- Toggle iVALID and iDATA (e.g. 25) during CONVERT of a 10 → display settles on 10 ({79,40}); 25 is accepted only if iVALID is still high in IDLE.
- Assert inRESET_SYNC low 3 edges into the conversion of 28 → no oDONE, oHEX blank, oREADY=1 after release. A subsequent 28 displays {24,00}.
- Exhaustive sweep 0..31 against a decimal reference model, checking the oDONE count equals the number of handshakes.
